// File: rtl/regfile_sb.sv
// Integer register file with pending-write scoreboard and sequenced soft-clear engine.
// Optional read-port write forwarding is compiled in with `define REGFILE_SB_BYPASS_EN.

module regfile_sb_entry #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            arst,
   input  logic            clr_i,
   input  logic            we_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic            set_i,
   input  logic            rel_i,
   output logic [XLEN-1:0] data_o,
   output logic            busy_o
);
   logic [XLEN-1:0] data_q, data_d;
   logic            busy_q, busy_d;

   // Clear has priority; otherwise a new mark outranks the retiring write.
   always_comb begin
      data_d = data_q;
      busy_d = busy_q;
      if (clr_i) begin
         data_d = '0;
         busy_d = 1'b0;
      end else begin
         if (we_i)       data_d = wdata_i;
         if (set_i)      busy_d = 1'b1;
         else if (rel_i) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         data_q <= '0;
         busy_q <= 1'b0;
      end else begin
         data_q <= data_d;
         busy_q <= busy_d;
      end
   end

   assign data_o = data_q;
   assign busy_o = busy_q;
endmodule

module regfile_sb #(
   parameter int XLEN     = 32,
   parameter int AW       = 5,
   parameter int ZERO_REG = 1
) (
   input  logic            clk,
   input  logic            arst,
   input  logic [AW-1:0]   rd_addr1,
   input  logic [AW-1:0]   rd_addr2,
   output logic [XLEN-1:0] rd_data1,
   output logic [XLEN-1:0] rd_data2,
   output logic            rd_busy1,
   output logic            rd_busy2,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic            mark_en,
   input  logic [AW-1:0]   mark_addr,
   input  logic            clr_req,
   output logic            clr_busy
);
   localparam int NREGS = 2**AW;
   localparam logic [AW-1:0] IDX_LAST = '1;
   localparam logic [AW-1:0] IDX_ONE  = AW'(1);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          idle;

   logic [NREGS-1:0][XLEN-1:0] rf_data;
   logic [NREGS-1:0]           rf_busy;

   assign idle     = (state_q == S_IDLE);
   assign clr_busy = (state_q == S_CLEAR);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (clr_req) begin
               state_d = S_CLEAR;
               idx_d   = '0;
            end
         end
         S_CLEAR: begin
            // idx wraps back to 0 on the final step.
            idx_d = idx_q + IDX_ONE;
            if (idx_q == IDX_LAST) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   for (genvar i = 0; i < NREGS; i++) begin : g_ent
      if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
         assign rf_data[i] = '0;
         assign rf_busy[i] = 1'b0;
      end else begin : g_reg
         logic we, set, clr;
         assign we  = idle && wr_en   && (wr_addr   == AW'(i));
         assign set = idle && mark_en && (mark_addr == AW'(i));
         assign clr = !idle && (idx_q == AW'(i));
         regfile_sb_entry #(.XLEN(XLEN)) u_ent (
            .clk    (clk),
            .arst   (arst),
            .clr_i  (clr),
            .we_i   (we),
            .wdata_i(wr_data),
            .set_i  (set),
            .rel_i  (we),
            .data_o (rf_data[i]),
            .busy_o (rf_busy[i])
         );
      end
   end

`ifdef REGFILE_SB_BYPASS_EN
   logic byp1, byp2;
   assign byp1 = idle && wr_en && (wr_addr == rd_addr1) && !((ZERO_REG != 0) && (rd_addr1 == '0));
   assign byp2 = idle && wr_en && (wr_addr == rd_addr2) && !((ZERO_REG != 0) && (rd_addr2 == '0));

   // A same-cycle mark to the forwarded address keeps the register pending.
   assign rd_data1 = byp1 ? wr_data : rf_data[rd_addr1];
   assign rd_data2 = byp2 ? wr_data : rf_data[rd_addr2];
   assign rd_busy1 = byp1 ? (mark_en && (mark_addr == rd_addr1)) : rf_busy[rd_addr1];
   assign rd_busy2 = byp2 ? (mark_en && (mark_addr == rd_addr2)) : rf_busy[rd_addr2];
`else
   assign rd_data1 = rf_data[rd_addr1];
   assign rd_data2 = rf_data[rd_addr2];
   assign rd_busy1 = rf_busy[rd_addr1];
   assign rd_busy2 = rf_busy[rd_addr2];
`endif

endmodule
